// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the 1011 sequence detector: valid/ready word intake, one bit per clk on x.
// Optional even-parity trailer bit is enabled by defining SER_PARITY_EN.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

`ifdef SER_PARITY_EN
  localparam int unsigned N = WIDTH + 1;
`else
  localparam int unsigned N = WIDTH;
`endif
  localparam int unsigned CW   = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  bit_cnt, cnt_nxt;
  logic [N-1:0]   shift_reg, shift_nxt;
  logic [N-1:0]   load_word;
  logic           x_nxt, x_valid_nxt;
  logic           last_bit, accept;

  // Parity rides at the far end of the shift register so it leaves after the payload.
`ifdef SER_PARITY_EN
  logic parity;
  assign parity    = ^data_in;
  assign load_word = MSB_FIRST ? {data_in, parity} : {parity, data_in};
`else
  assign load_word = data_in;
`endif

  function automatic logic out_bit(input logic [N-1:0] v);
    return MSB_FIRST ? v[N-1] : v[0];
  endfunction

  assign last_bit   = (state == SHIFT) && (bit_cnt == LAST);
  assign data_ready = reset & ((state == IDLE) | last_bit);
  assign accept     = data_valid & data_ready;
  assign busy       = (state != IDLE);
  assign word_done  = x_valid & last_bit;

  // State and datapath registers; reset drops any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      x         <= IDLE_BIT;
      x_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      shift_reg <= shift_nxt;
      x         <= x_nxt;
      x_valid   <= x_valid_nxt;
    end
  end

  // Next-state and datapath: a word loaded at last_bit streams on with no bubble.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = bit_cnt;
    shift_nxt   = shift_reg;
    x_valid_nxt = x_valid;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = SHIFT;
          cnt_nxt     = '0;
          shift_nxt   = load_word;
          x_valid_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          cnt_nxt = '0;
          if (accept) begin
            shift_nxt   = load_word;
            x_valid_nxt = 1'b1;
          end else begin
            state_nxt   = IDLE;
            shift_nxt   = '0;
            x_valid_nxt = 1'b0;
          end
        end else begin
          cnt_nxt     = bit_cnt + CW'(1);
          shift_nxt   = MSB_FIRST ? {shift_reg[N-2:0], 1'b0} : {1'b0, shift_reg[N-1:1]};
          x_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        shift_nxt   = '0;
        x_valid_nxt = 1'b0;
      end
    endcase
    x_nxt = x_valid_nxt ? out_bit(shift_nxt) : IDLE_BIT;
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: MSB-first and LSB-first instances, back-to-back words,
// 1011 occurrence count on the stream, async reset mid-word; parity stream when SER_PARITY_EN is set.
module tb_serial_bit_feeder;

  logic       clk;
  logic       reset;
  logic [7:0] data_in, data_in_l;
  logic       data_valid, valid_l;
  logic       data_ready, x, x_valid, busy, word_done;
  logic       ready_l, x_l, xv_l, busy_l, wd_l;

  int total = 0;
  int bad   = 0;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .x(x), .x_valid(x_valid), .busy(busy), .word_done(word_done)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in_l), .data_valid(valid_l),
    .data_ready(ready_l), .x(x_l), .x_valid(xv_l), .busy(busy_l), .word_done(wd_l)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_x"}, x, 1'b0);
    chk({tag, "_xv"}, x_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_wd"}, word_done, 1'b0);
  endtask

  logic [7:0]  exp1, exp4, exp5;
  logic [15:0] exp2;
  logic [17:0] exp6;
  logic [3:0]  hist;
  int          nbits, z_cnt;

  initial begin
    exp1 = 8'b1011_0000;   // 8'hB0 MSB first
    exp4 = 8'b1011_0000;   // 8'h0D LSB first
    exp2 = 16'b1011_0000_0000_1011;
    exp5 = 8'b1001_0110;   // 8'h96 MSB first
    exp6 = 18'b1011_0000_1_1011_0001_0;
    reset = 1'b0;
    data_in = 8'hB0;
    data_valid = 1'b1;
    data_in_l = 8'h0D;
    valid_l = 1'b0;
`ifndef SER_PARITY_EN
    valid_l = 1'b1;
`endif
    #1;
    chk_idle("rst");
    chk("rst_ready", data_ready, 1'b0);
    step();
    chk("rst_ready_edge", data_ready, 1'b0);
    chk_idle("rst_edge");
    #4;
    reset = 1'b1;
    #1;
    chk("rel_ready", data_ready, 1'b1);
    step();

`ifdef SER_PARITY_EN
    data_in = 8'hB1;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) step();
      chk($sformatf("par_x%0d", i), x, exp6[17-i]);
      chk($sformatf("par_xv%0d", i), x_valid, 1'b1);
      chk($sformatf("par_rdy%0d", i), data_ready, (i == 8) || (i == 17));
      chk($sformatf("par_wd%0d", i), word_done, (i == 8) || (i == 17));
      if (i == 17) data_valid = 1'b0;
    end
    step();
    chk_idle("par_end");
`else
    // Word 8'hB0 MSB first alongside 8'h0D LSB first.
    data_valid = 1'b0;
    valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk($sformatf("t1_x%0d", i), x, exp1[7-i]);
      chk($sformatf("t1_xv%0d", i), x_valid, 1'b1);
      chk($sformatf("t1_wd%0d", i), word_done, i == 7);
      chk($sformatf("t1_busy%0d", i), busy, 1'b1);
      chk($sformatf("t4_x%0d", i), x_l, exp4[7-i]);
      chk($sformatf("t4_xv%0d", i), xv_l, 1'b1);
      chk($sformatf("t4_wd%0d", i), wd_l, i == 7);
    end
    step();
    chk_idle("t1_end");
    chk("t1_end_ready", data_ready, 1'b1);
    chk("t4_end_xv", xv_l, 1'b0);

    // Back-to-back 8'hB0, 8'h0B with data_valid held high.
    data_in = 8'hB0;
    data_valid = 1'b1;
    hist = 4'h0;
    nbits = 0;
    z_cnt = 0;
    step();
    data_in = 8'h0B;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      chk($sformatf("t2_x%0d", i), x, exp2[15-i]);
      chk($sformatf("t2_xv%0d", i), x_valid, 1'b1);
      chk($sformatf("t2_rdy%0d", i), data_ready, (i == 7) || (i == 15));
      chk($sformatf("t2_wd%0d", i), word_done, (i == 7) || (i == 15));
      if (x_valid) begin
        hist = {hist[2:0], x};
        nbits++;
        if (nbits >= 4 && hist == 4'b1011) z_cnt++;
      end
      if (i == 15) data_valid = 1'b0;
    end
    chki("t3_z_count", z_cnt, 2);
    step();
    chk_idle("t2_end");

    // Async reset on the 4th bit of 8'hFF.
    data_in = 8'hFF;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    chk("t5_x0", x, 1'b1);
    step();
    step();
    step();
    chk("t5_x3", x, 1'b1);
    chk("t5_xv3", x_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("t5_rst");
    chk("t5_rst_ready", data_ready, 1'b0);
    #2;
    reset = 1'b1;
    step();
    chk_idle("t5_rel");
    data_in = 8'h96;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk($sformatf("t5_x%0d", i), x, exp5[7-i]);
      chk($sformatf("t5_xv%0d", i), x_valid, 1'b1);
      chk($sformatf("t5_wd%0d", i), word_done, i == 7);
    end
    step();
    chk_idle("t5_end");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
